whirlpool_wcipher_inv_sbox_engine: RTL and testbench

- Iterative inverse-SubBytes engine for the Whirlpool W-cipher decrypt / key-check path.
- Accepts a full 512-bit state over a valid/ready handshake and applies the inverse S-box to every byte, LANES bytes per cycle.
- Returns the substituted state over a second valid/ready handshake.
- Each inverse S-box instance inverts the forward mini-box structure (E, E-inverse, R) combinationally; the engine adds sequencing, buffering and flow control around it.

---
 rtl/whirlpool_wcipher_inv_sbox_engine.sv | 114 +++++++++++
 tb/tb_whirlpool_wcipher_inv_sbox_engine.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/whirlpool_wcipher_inv_sbox_engine.sv
`default_nettype none
// ============================================================================
// Module   : whirlpool_wcipher_inv_sbox_engine
// Brief    : Iterative Whirlpool inverse-SubBytes engine, LANES bytes per cycle,
//            valid/ready in and out, single state in flight.
// Revision : 1.0 - initial release
// ============================================================================
module whirlpool_wcipher_inv_sbox_engine #(
  parameter int STATE_BYTES = 64,
  parameter int LANES       = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8*STATE_BYTES-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [8*STATE_BYTES-1:0] out_data,
  output logic                     busy
);

  localparam int C_CHUNKS = STATE_BYTES / LANES;
  localparam int C_CW     = (C_CHUNKS > 1) ? $clog2(C_CHUNKS) : 1;
  localparam logic [C_CW-1:0] C_LAST = C_CW'(C_CHUNKS - 1);

  // Mini-box tables, nibble i at bits [4i+3:4i].
  localparam logic [63:0] C_E_TAB    = 64'h052A_478E_3F6D_C9B1;
  localparam logic [63:0] C_EINV_TAB = 64'h6843_1C29_A5EB_7D0F;
  localparam logic [63:0] C_R_TAB    = 64'h0152_A836_F94E_DBC7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                              r_state;
  logic [C_CW-1:0]                     r_cnt;
  logic [C_CHUNKS-1:0][LANES-1:0][7:0] r_work;
  logic [LANES-1:0][7:0]               w_sub;

  function automatic logic [3:0] nib(input logic [63:0] tab, input logic [3:0] idx);
    return tab[{idx, 2'b00} +: 4];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [3:0] g, h, d;
    g = nib(C_E_TAB, y[3:0]);
    h = nib(C_EINV_TAB, y[7:4]);
    d = nib(C_R_TAB, g ^ h);
    return {nib(C_EINV_TAB, h ^ d), nib(C_E_TAB, g ^ d)};
  endfunction

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign w_sub[l] = inv_sbox(r_work[r_cnt][l]);
    end
  endgenerate

  assign out_data = r_work;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_work    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            r_work   <= in_data;
            r_cnt    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            r_state  <= S_BUSY;
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_BUSY: begin
          r_work[r_cnt] <= w_sub;
          if (r_cnt == C_LAST) begin
            r_cnt     <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + C_CW'(1);
          end
        end
        S_DONE: begin
          // in_ready reopens on the output transfer edge itself.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_whirlpool_wcipher_inv_sbox_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_whirlpool_wcipher_inv_sbox_engine
// Brief    : Directed bench for the inverse S-box engine at LANES = 8, 1 and 64.
// Revision : 1.0 - initial release
// ============================================================================
module tb_whirlpool_wcipher_inv_sbox_engine;

  localparam int SB = 64;
  localparam int W  = 8 * SB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         rdy8, vld8, busy8, rdy1, vld1, busy1, rdy64, vld64, busy64;
  logic [W-1:0] dat8, dat1, dat64;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  whirlpool_wcipher_inv_sbox_engine #(.STATE_BYTES(SB), .LANES(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8), .in_data(in_data),
    .out_valid(vld8), .out_ready(out_ready), .out_data(dat8), .busy(busy8));

  whirlpool_wcipher_inv_sbox_engine #(.STATE_BYTES(SB), .LANES(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .out_valid(vld1), .out_ready(out_ready), .out_data(dat1), .busy(busy1));

  whirlpool_wcipher_inv_sbox_engine #(.STATE_BYTES(SB), .LANES(64)) dut_l64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64), .in_data(in_data),
    .out_valid(vld64), .out_ready(out_ready), .out_data(dat64), .busy(busy64));

  // Forward Whirlpool mini-boxes in natural order.
  int e_t[16]  = '{1, 11, 9, 12, 13, 6, 15, 3, 14, 8, 7, 4, 10, 2, 5, 0};
  int ei_t[16] = '{15, 0, 13, 7, 11, 14, 5, 10, 9, 2, 12, 1, 3, 4, 8, 6};
  int r_t[16]  = '{7, 12, 11, 13, 14, 4, 9, 15, 6, 3, 8, 10, 2, 5, 1, 0};
  logic [7:0] inv_t[256];

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] exp;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    int u, l, r;
    u = e_t[x[7:4]];
    l = ei_t[x[3:0]];
    r = r_t[u ^ l];
    return {4'(e_t[u ^ r]), 4'(ei_t[l ^ r])};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] d);
    int n;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    while (!rdy8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rdy8) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready got 0, expected 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(input int k, input bit all);
    int lat8, lat1, lat64;
    logic busy_first;
    lat8 = -1; lat1 = -1; lat64 = -1; busy_first = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) busy_first = busy8;
      if (vld8 && lat8 < 0) lat8 = c;
      if (vld1 && lat1 < 0) lat1 = c;
      if (vld64 && lat64 < 0) lat64 = c;
      if (lat8 >= 0 && (!all || (lat1 >= 0 && lat64 >= 0))) break;
    end
    chk($sformatf("busy_v%0d", k), W'(busy_first), W'(1));
    chk($sformatf("latency_l8_v%0d", k), W'(lat8), W'(8));
    chk($sformatf("data_l8_v%0d", k), dat8, vecs[k].exp);
    if (all) begin
      chk($sformatf("latency_l1_v%0d", k), W'(lat1), W'(64));
      chk($sformatf("data_l1_v%0d", k), dat1, vecs[k].exp);
      chk($sformatf("latency_l64_v%0d", k), W'(lat64), W'(1));
      chk($sformatf("data_l64_v%0d", k), dat64, vecs[k].exp);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] s_in[3];
    logic [W-1:0] s_exp[3];
    logic         acc_pend;
    int           acc, nout, last, c;

    for (int x = 0; x < 256; x++) inv_t[fwd_sbox(8'(x))] = 8'(x);

    vecs[0].din = '0;
    vecs[1].din = {{60{8'h18}}, 8'h01, 8'h86, 8'h23, 8'h18};
    vecs[1].exp = {{60{8'h00}}, 8'h06, 8'hFF, 8'h01, 8'h00};
    for (int k = 2; k < 6; k++)
      for (int b = 0; b < SB; b++) vecs[k].din[8*b +: 8] = 8'(64 * (k - 2) + b);
    for (int k = 0; k < 6; k++)
      if (k != 1)
        for (int b = 0; b < SB; b++) vecs[k].exp[8*b +: 8] = inv_t[vecs[k].din[8*b +: 8]];

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_in_ready", W'(rdy8), W'(0));
    chk("rst_out_valid", W'(vld8), W'(0));
    chk("rst_busy", W'(busy8), W'(0));
    chk("rst_out_data", dat8, '0);
    rst_n    = 1'b1;
    in_data  = '0;
    in_valid = 1'b1;
    @(negedge clk);
    chk("in_ready_first_edge", W'(rdy8), W'(1));

    // Table-driven vectors across all three lane widths
    for (int k = 0; k < 6; k++) begin
      send(vecs[k].din);
      collect(k, 1'b1);
    end

    // Backpressure in DONE
    send(vecs[1].din);
    c = 0;
    while (!vld8 && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("bp_reach_done", W'(vld8), W'(1));
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = {16{$urandom}};
      @(negedge clk);
      chk("bp_out_valid", W'(vld8), W'(1));
      chk("bp_out_data", dat8, vecs[1].exp);
      chk("bp_in_ready", W'(rdy8), W'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_valid", W'(vld8), W'(0));
    chk("bp_release_ready", W'(rdy8), W'(1));
    chk("bp_no_accept", W'(busy8), W'(0));

    // Reset mid-BUSY at counter 3
    send(vecs[2].din);
    repeat (3) @(negedge clk);
    chk("midrst_busy_before", W'(busy8), W'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", W'(vld8), W'(0));
    chk("midrst_busy", W'(busy8), W'(0));
    chk("midrst_in_ready", W'(rdy8), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    send(vecs[3].din);
    collect(3, 1'b0);

    // Back-to-back with in_valid and out_ready held high
    s_in[0] = vecs[1].din; s_exp[0] = vecs[1].exp;
    s_in[1] = vecs[4].din; s_exp[1] = vecs[4].exp;
    s_in[2] = vecs[5].din; s_exp[2] = vecs[5].exp;
    in_data   = s_in[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    acc_pend  = rdy8;
    acc = 0; nout = 0; last = -1;
    for (int cyc = 0; cyc < 80 && nout < 3; cyc++) begin
      @(negedge clk);
      if (acc_pend) begin
        acc++;
        if (acc < 3) in_data = s_in[acc];
        else in_valid = 1'b0;
      end
      acc_pend = rdy8 && in_valid;
      if (vld8) begin
        chk($sformatf("b2b_data_%0d", nout), dat8, s_exp[nout]);
        if (nout > 0) chk($sformatf("b2b_spacing_%0d", nout), W'(cyc - last), W'(10));
        last = cyc;
        nout++;
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("b2b_out_count", W'(nout), W'(3));
    chk("b2b_in_count", W'(acc), W'(3));
    repeat (12) @(negedge clk);
    chk("b2b_idle_valid", W'(vld8), W'(0));
    chk("b2b_idle_busy", W'(busy8), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
